// File: rtl/video_timing_probe.sv
// video_timing_probe: measures incoming VDP timing (active pixels per line,
// lines per frame, line period, interlace state), declares the resolution
// stable after a run of identical frames, filters spurious HSync edges,
// regenerates a fixed-width HSync and produces DE- or window-based blanking.
module video_timing_probe #(
  parameter int CW            = 13,
  parameter int HW            = 10,
  parameter int VW            = 10,
  parameter int HS_PULSE      = 504,
  parameter int HS_GAP_MIN    = 4096,
  parameter int STABLE_FRAMES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          de_h,
  input  logic          de_v,
  input  logic          field,
  input  logic          border_en,
  input  logic [CW-1:0] hbl_start,
  input  logic [CW-1:0] hbl_end,
  input  logic [VW-1:0] vbl_start,
  input  logic [VW-1:0] vbl_end,
  output logic          hs_out,
  output logic          hbl,
  output logic          vbl,
  output logic [HW-1:0] line_pix,
  output logic [VW-1:0] frame_lines,
  output logic [CW-1:0] line_clks,
  output logic          f1,
  output logic          interlace,
  output logic          res_valid,
  output logic          res_changed
);

  localparam int MW = (STABLE_FRAMES > 1) ? $clog2(STABLE_FRAMES) : 1;
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES - 1);
  localparam logic [CW:0]   GAP_MIN   = (CW + 1)'(HS_GAP_MIN);
  localparam logic [CW-1:0] HS_END    = CW'(HS_PULSE - 1);

  typedef enum logic {ARM, RUN} state_t;

  function automatic logic [CW-1:0] sat_inc_c(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [HW-1:0] sat_inc_h(input logic [HW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [VW-1:0] sat_inc_v(input logic [VW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic          hs_p0, vs_p0;
  logic          hs_fall, vs_fall, accept;
  logic [CW-1:0] hcnt;
  logic [HW-1:0] pcnt, pmax, pmax_acc;
  logic [VW-1:0] lcnt, lcnt_acc;
  logic          have_latch, same_res;
  logic [MW-1:0] match, match_nx;
  state_t        state, state_next;
  logic          frame_clr, do_latch;

  // Edge detection; idle level of both syncs is high so no edge follows reset
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_p0 <= 1'b1;
      vs_p0 <= 1'b1;
    end else begin
      hs_p0 <= hs_in;
      vs_p0 <= vs_in;
    end
  end

  assign hs_fall = hs_p0 & ~hs_in;
  assign vs_fall = vs_p0 & ~vs_in;
  // Double pulses in the blanking gap are ignored; inside active video every edge counts
  assign accept  = hs_fall & (({1'b0, hcnt} >= GAP_MIN) | de_v);

  // Values as they stand after an accept in this clk, so a line ending together with VSync is included
  assign pmax_acc = accept ? ((pcnt > pmax) ? pcnt : pmax) : pmax;
  assign lcnt_acc = accept ? sat_inc_v(lcnt) : lcnt;

  // Line timer, line period measurement and regenerated HSync
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt      <= '0;
      line_clks <= '0;
      hs_out    <= 1'b1;
    end else if (accept) begin
      line_clks <= sat_inc_c(hcnt);
      hcnt      <= '0;
      hs_out    <= 1'b0;
    end else begin
      hcnt <= sat_inc_c(hcnt);
      if (hcnt == HS_END) hs_out <= 1'b1;
    end
  end

  // Pixel and line counters; a VSync edge restarts the per-frame accumulators
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      pmax <= '0;
      lcnt <= '0;
    end else begin
      if (accept)               pcnt <= '0;
      else if (ce_pix && de_h)  pcnt <= sat_inc_h(pcnt);
      if (frame_clr) begin
        pmax <= '0;
        lcnt <= '0;
      end else begin
        pmax <= pmax_acc;
        lcnt <= lcnt_acc;
      end
    end
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (reset) state <= ARM;
    else       state <= state_next;
  end

  // Frame next-state: the first VSync after reset only aligns to a frame start
  always_comb begin
    state_next = state;
    if (state == ARM && vs_fall) state_next = RUN;
  end

  // Frame outputs: clear on every VSync, latch only once aligned
  always_comb begin
    frame_clr = vs_fall;
    do_latch  = 1'b0;
    if (state == RUN && vs_fall) do_latch = 1'b1;
  end

  // Stability tracking against the previously latched resolution
  always_comb begin
    same_res = have_latch && ({pmax_acc, lcnt_acc} == {line_pix, frame_lines});
    match_nx = '0;
    if (same_res) match_nx = (match == MATCH_MAX) ? match : match + 1'b1;
  end

  // Frame measurement latch, field state and resolution validity
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_lines <= '0;
      line_pix    <= '0;
      f1          <= 1'b0;
      interlace   <= 1'b0;
      have_latch  <= 1'b0;
      match       <= '0;
      res_valid   <= 1'b0;
      res_changed <= 1'b0;
    end else begin
      res_changed <= 1'b0;
      if (do_latch) begin
        frame_lines <= lcnt_acc;
        line_pix    <= pmax_acc;
        f1          <= field;
        interlace   <= f1 ^ field;
        have_latch  <= 1'b1;
        match       <= match_nx;
        res_valid   <= (match_nx == MATCH_MAX);
        res_changed <= res_valid & ~same_res;
      end
    end
  end

  // Registered blanking; an inverted window (start > end) blanks everything
  always_ff @(posedge clk) begin
    if (reset) begin
      hbl <= 1'b1;
      vbl <= 1'b1;
    end else begin
      hbl <= border_en ? ~((hcnt >= hbl_start) && (hcnt <= hbl_end)) : ~de_h;
      vbl <= border_en ? ~((lcnt >= vbl_start) && (lcnt <= vbl_end)) : ~de_v;
    end
  end

endmodule
